// File: rtl/mult_pkg.sv
// Shared types and width helpers for the product accumulator slice.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

  function automatic int acc_width(input int width, input int guard);
    return 2 * width + guard;
  endfunction

  function automatic int cnt_width(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/mult_product_accumulator_if.sv
// Product-in / accumulated-result-out handshake bundle for mult_product_accumulator.
interface mult_product_accumulator_if
  import mult_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int GUARD     = 8,
  parameter int MAX_BEATS = 64
);
  localparam int PW = 2 * WIDTH;
  localparam int AW = acc_width(WIDTH, GUARD);
  localparam int CW = cnt_width(MAX_BEATS);

  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_p;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_acc;
  logic [CW-1:0] out_count;
  logic          out_ovf;

  modport master (
    output in_valid, in_p, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_p, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_ovf
  );

endinterface

// File: rtl/mult_acc_adder.sv
// Accumulator adder: acc + zero-extended product, with carry-out and a clamped sum.
module mult_acc_adder #(
  parameter int PW = 128,
  parameter int AW = 136
) (
  input  logic [AW-1:0] acc,
  input  logic [PW-1:0] prod,
  output logic [AW-1:0] sum,
  output logic          carry,
  output logic [AW-1:0] sat_sum
);

  logic [AW:0] full;

  assign full    = {1'b0, acc} + {{(AW + 1 - PW){1'b0}}, prod};
  assign sum     = full[AW-1:0];
  assign carry   = full[AW];
  // Once clamped, acc is all-ones, so any further beat clamps again.
  assign sat_sum = carry ? {AW{1'b1}} : sum;

endmodule

// File: rtl/mult_product_accumulator.sv
// Sums packets of multiplier products into a wide accumulator, one result per packet.
// Optional MULT_ACC_SATURATE_EN: clamp to all-ones on overflow instead of wrapping.
module mult_product_accumulator
  import mult_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int GUARD     = 8,
  parameter int MAX_BEATS = 64
) (
  input logic                        clk,
  input logic                        rst_n,
  mult_product_accumulator_if.slave  bus
);

  localparam int PW = 2 * WIDTH;
  localparam int AW = acc_width(WIDTH, GUARD);
  localparam int CW = cnt_width(MAX_BEATS);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BEATS);

`ifdef MULT_ACC_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  acc_state_t    state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          in_ready_q;
  logic          out_valid_q;

  logic          beat;
  logic [AW-1:0] add_base;
  logic [AW-1:0] add_sum;
  logic [AW-1:0] add_sat;
  logic [AW-1:0] add_res;
  logic          add_carry;

  assign beat = bus.in_valid && in_ready_q;

  // The first beat of a packet adds onto zero, which also makes its carry impossible.
  assign add_base = (state_q == IDLE) ? '0 : acc_q;

  mult_acc_adder #(
    .PW (PW),
    .AW (AW)
  ) u_adder (
    .acc     (add_base),
    .prod    (bus.in_p),
    .sum     (add_sum),
    .carry   (add_carry),
    .sat_sum (add_sat)
  );

  assign add_res = SAT_EN ? add_sat : add_sum;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (beat) begin
          acc_d   = add_res;
          count_d = CW'(1);
          ovf_d   = 1'b0;
          state_d = (bus.in_last || MAX_BEATS == 1) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_d   = add_res;
          count_d = count_q + 1'b1;
          ovf_d   = ovf_q | add_carry;
          state_d = (bus.in_last || count_d == MAX_CNT) ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      // Handshake flags are registered decodes of the next state, so outputs carry no input path.
      in_ready_q  <= (state_d != HOLD);
      out_valid_q <= (state_d == HOLD);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = acc_q;
  assign bus.out_count = count_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_mult_product_accumulator.sv
// Self-checking bench: a GUARD=2 and a GUARD=0 accumulator share one stimulus stream.
module tb_mult_product_accumulator;

`ifdef MULT_ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mult_product_accumulator_if #(.WIDTH(4), .GUARD(2), .MAX_BEATS(4)) bus ();
  mult_product_accumulator_if #(.WIDTH(4), .GUARD(0), .MAX_BEATS(4)) bus_g0 ();

  assign bus_g0.in_valid  = bus.in_valid;
  assign bus_g0.in_p      = bus.in_p;
  assign bus_g0.in_last   = bus.in_last;
  assign bus_g0.out_ready = bus.out_ready;

  mult_product_accumulator #(.WIDTH(4), .GUARD(2), .MAX_BEATS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mult_product_accumulator #(.WIDTH(4), .GUARD(0), .MAX_BEATS(4)) dut_g0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_g0)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: a packet's result is the plain sum of its products, reduced to the accumulator width.
  function automatic void model(input int unsigned beats[$], input int aw,
                                output longint unsigned acc, output bit ovf);
    longint unsigned total = 0;
    longint unsigned lim;
    foreach (beats[i]) total += beats[i];
    lim = 64'd1 << aw;
    ovf = (total >= lim);
    acc = (ovf && SAT) ? lim - 1 : total % lim;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] p, input logic last);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_p     = p;
    bus.in_last  = last;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("beat_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic run_packet(input int unsigned beats[$], input bit close_last,
                            input int hold, input int gap, input string tag);
    longint unsigned e_acc, e_acc0;
    bit e_ovf, e_ovf0;
    int n = beats.size();
    model(beats, 6 + 4, e_acc, e_ovf);
    model(beats, 8, e_acc0, e_ovf0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      send_beat(8'(beats[i]), close_last && (i == n - 1));
      if (i != n - 1) repeat (gap) tick();
    end
    check({tag, "_valid"}, bus.out_valid, 1);
    check({tag, "_acc"}, bus.out_acc, e_acc);
    check({tag, "_count"}, bus.out_count, n);
    check({tag, "_ovf"}, bus.out_ovf, e_ovf);
    check({tag, "_g0_acc"}, bus_g0.out_acc, e_acc0);
    check({tag, "_g0_ovf"}, bus_g0.out_ovf, e_ovf0);
    check({tag, "_busy"}, bus.in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, "_hold_valid"}, bus.out_valid, 1);
      check({tag, "_hold_acc"}, bus.out_acc, e_acc);
    end
    bus.out_ready = 1'b1;
    tick();
    check({tag, "_drained"}, bus.out_valid, 0);
    check({tag, "_acc_kept"}, bus.out_acc, e_acc);
    check({tag, "_idle_ready"}, bus.in_ready, 1);
  endtask

  initial begin
    int unsigned q[$];
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_p      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state.
    repeat (2) tick();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_acc", bus.out_acc, 0);
    check("rst_count", bus.out_count, 0);
    check("rst_ovf", bus.out_ovf, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", bus.in_ready, 1);

    // Three products closed by in_last.
    q = {15, 6, 49};
    run_packet(q, 1'b1, 0, 0, "dot3");

    // Auto-close at MAX_BEATS, then a fresh single-beat packet.
    q = {225, 225, 225, 225};
    run_packet(q, 1'b0, 1, 0, "autoclose");
    q = {225};
    run_packet(q, 1'b1, 0, 0, "fifth");

    // in_last on the MAX_BEATS beat closes only once.
    q = {1, 2, 3, 4};
    run_packet(q, 1'b1, 0, 1, "last_at_max");

    // Wrap / clamp on the narrow accumulator.
    q = {225, 100};
    run_packet(q, 1'b1, 0, 0, "wrap");

    // Zero products still count.
    q = {0, 0, 0};
    run_packet(q, 1'b1, 0, 0, "zeros");

    // Backpressure: result held, offered beat refused until the FSM is idle again.
    bus.out_ready = 1'b0;
    send_beat(8'd5, 1'b0);
    send_beat(8'd7, 1'b1);
    check("bp_valid", bus.out_valid, 1);
    check("bp_acc", bus.out_acc, 12);
    bus.in_valid = 1'b1;
    bus.in_p     = 8'd3;
    bus.in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_hold_valid", bus.out_valid, 1);
      check("bp_hold_acc", bus.out_acc, 12);
      check("bp_hold_count", bus.out_count, 2);
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_valid", bus.out_valid, 0);
    check("bp_release_ready", bus.in_ready, 1);
    tick();
    check("bp_next_valid", bus.out_valid, 1);
    check("bp_next_acc", bus.out_acc, 3);
    check("bp_next_count", bus.out_count, 1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    tick();

    // Reset in the middle of a packet discards it.
    bus.out_ready = 1'b0;
    send_beat(8'd10, 1'b0);
    send_beat(8'd11, 1'b0);
    rst_n = 1'b0;
    tick();
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_ready", bus.in_ready, 0);
    check("midrst_acc", bus.out_acc, 0);
    check("midrst_count", bus.out_count, 0);
    rst_n = 1'b1;
    tick();
    check("midrst_no_result", bus.out_valid, 0);
    q = {9};
    run_packet(q, 1'b1, 0, 0, "after_rst");

    // Back-to-back single-beat packets with in_valid held high.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_last   = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      bus.in_p = 8'(k);
      check("b2b_ready", bus.in_ready, 1);
      tick();
      check("b2b_valid", bus.out_valid, 1);
      check("b2b_acc", bus.out_acc, k);
      check("b2b_count", bus.out_count, 1);
      check("b2b_busy", bus.in_ready, 0);
      tick();
      check("b2b_drained", bus.out_valid, 0);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;

    // Randomized packets against the reference model.
    for (int pk = 0; pk < 25; pk++) begin
      int n = $urandom_range(1, 4);
      bit cl;
      q = {};
      for (int b = 0; b < n; b++) q.push_back($urandom_range(0, 15) * $urandom_range(0, 15));
      cl = (n < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      run_packet(q, cl, $urandom_range(0, 3), $urandom_range(0, 2), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_product_accumulator.md
Name: mult_product_accumulator

Overview:
- Downstream consumer of the generic unsigned m x n array multiplier: accepts a stream of 2*WIDTH-bit products and sums each packet into a wide accumulator.
- Emits one accumulated result per packet.
- Gives the combinational multiplier a registered, handshaked sink for dot-product / MAC use.
- Input beats are delimited by in_last or by reaching MAX_BEATS.

Parameters:
- WIDTH, 64, operand width of the upstream multiplier; product input is 2*WIDTH bits.
- GUARD, 8, extra accumulator MSBs above 2*WIDTH.
- MAX_BEATS, 64, maximum products per packet; a packet closes automatically at this count.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  product beat valid
- in_ready  output  1  block can accept a beat
- in_p  input  2*WIDTH  unsigned product from the multiplier
- in_last  input  1  final beat of packet
- out_valid  output  1  accumulated result valid
- out_ready  input  1  downstream accepts result
- out_acc  output  2*WIDTH+GUARD  packet sum
- out_count  output  $clog2(MAX_BEATS+1)  beats in packet
- out_ovf  output  1  sticky overflow for packet

Behaviour:
- Reset (rst_n low at a rising edge): state=IDLE, acc=0, count=0, ovf=0, out_valid=0, in_ready=0 during reset cycle, 1 the cycle after. Reset mid-packet or during HOLD discards all state; no result is emitted.
- FSM states: IDLE, ACCUM, HOLD.
- Beat accepted when in_valid && in_ready.
- in_ready=1 in IDLE and ACCUM, 0 in HOLD. No skid buffer.
- IDLE, accepted beat: acc<=zero-ext(in_p), count<=1, ovf<=0. Next state is HOLD if in_last or MAX_BEATS==1, else ACCUM.
- ACCUM, accepted beat: acc<=acc+zero-ext(in_p), count<=count+1. Next state is HOLD if in_last or count+1==MAX_BEATS.
- ACCUM, no beat: hold all state. No timeout.
- Arithmetic: unsigned, width 2*WIDTH+GUARD. A carry out of the MSB sets ovf (sticky until the next packet starts), and acc wraps modulo 2^(2*WIDTH+GUARD).
- HOLD: out_valid=1; out_acc, out_count and out_ovf are registered and stable while out_valid && !out_ready.
- HOLD with out_ready: next cycle is IDLE with out_valid=0. acc/count are not cleared until the next first beat, so out_acc holds its last value while out_valid=0.
- Latency: out_valid rises exactly 1 cycle after the closing beat is accepted. Min packet period is 2 cycles for a 1-beat packet with out_ready tied high.
- in_p=0 beats count normally.
- in_last asserted on beat MAX_BEATS closes the packet once. No empty packet follows.
- Outputs are purely registered; no combinational in->out path. in_ready depends only on state.

Optional Feature:
- Macro: MULT_ACC_SATURATE_EN.
- Defined: on carry out, acc clamps to all-ones and stays there for the rest of the packet. ovf is still set.
- Undefined: modulo wrap as above.

Decomposition:
- Shared package mult_pkg holds:
  - state enum acc_state_t {IDLE, ACCUM, HOLD}
  - function acc_width(width, guard) = 2*width+guard
  - function cnt_width(max_beats) = $clog2(max_beats+1)
- One natural sub-module: mult_acc_adder. Combinational: acc plus zero-extended product. Outputs sum, carry, and the optional saturated sum.
- FSM and registers stay in the top.

Test Plan (WIDTH=4, GUARD=2, MAX_BEATS=4 unless noted):
- Beats in_p=15 (3*5), 6 (2*3), 49 (7*7, in_last), out_ready=1 -> out_valid one cycle after the third beat; out_acc=70, out_count=3, out_ovf=0.
- Four beats of 225 (15*15), in_last never set -> auto-close at beat 4; out_acc=900 mod 1024=900, out_count=4, ovf=0. Then a fifth beat of 225 starts a new packet with count=1.
- GUARD=0, beats 225 and 100 -> wrap: out_acc=69, out_ovf=1. With MULT_ACC_SATURATE_EN: out_acc=255, out_ovf=1.
- out_ready held low 5 cycles in HOLD while in_valid=1 -> in_ready=0, out_acc/out_count stable. Beats are accepted only after out_ready is high and the FSM returns to IDLE.
- rst_n low for 1 cycle after 2 beats of a packet (sum 21) -> no out_valid. Next packet with single beat 9 (in_last) gives out_acc=9, out_count=1.
- Back-to-back single-beat packets 1, 2, 3 (in_last each), out_ready=1 -> results 1, 2, 3 in order, each 1 cycle after acceptance; in_ready alternates 1/0.
